// File: rtl/spi_master_protocol_pkg.sv
// Shared definitions for the SPI master transaction layer: default widths and FSM state encoding.
package spi_master_protocol_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_GAP_CYCLES = 4;

  typedef enum logic [2:0] {
    SM_IDLE = 3'd0,
    SM_CMD  = 3'd1,
    SM_GAP1 = 3'd2,
    SM_DATA = 3'd3,
    SM_GAP2 = 3'd4,
    SM_DONE = 3'd5
  } sm_state_e;

endpackage

// File: rtl/spi_master_protocol.sv
// SPI initiator transaction layer: one host request becomes a config frame followed by a data
// frame on the shift front-end, with forced idle gaps so the slave re-synchronises between frames.
module spi_master_protocol
  import spi_master_protocol_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_rnw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              fe_start,
  output logic [DATA_W-1:0] fe_data_out,
  input  logic [DATA_W-1:0] fe_data_in,
  input  logic              fe_done,
  output logic [2:0]        dbg_state
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  // Handshake: a request is taken on a rising edge where req=1 and ready=1; ready then stays
  // low until the cycle after the one-cycle ack pulse. Requests seen while ready=0 are dropped.

  sm_state_e         state_q;
  logic              ready_q;
  logic              ack_q;
  logic              fe_start_q;
  logic [DATA_W-1:0] fe_data_q;
  logic [DATA_W-1:0] rdata_q;
  logic [GAP_W-1:0]  gap_q;
  logic              rnw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] req_cfg;

  always_comb begin
    req_cfg             = '0;
    req_cfg[ADDR_W-1:0] = req_addr;
    req_cfg[ADDR_W]     = req_rnw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SM_IDLE;
      ready_q    <= 1'b1;
      ack_q      <= 1'b0;
      fe_start_q <= 1'b0;
      fe_data_q  <= '0;
      rdata_q    <= '0;
      gap_q      <= '0;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      fe_start_q <= 1'b0;
      ack_q      <= 1'b0;
      case (state_q)
        SM_IDLE: begin
          // ready is held low through the ack cycle so the next accept lands one cycle later
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else if (req) begin
            rnw_q      <= req_rnw;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            ready_q    <= 1'b0;
            fe_start_q <= 1'b1;
            fe_data_q  <= req_cfg;
            gap_q      <= '0;
            state_q    <= SM_CMD;
          end
        end
        SM_CMD: begin
          if (fe_done && !fe_start_q) begin
            gap_q   <= '0;
            state_q <= SM_GAP1;
          end
        end
        SM_GAP1: begin
          if (gap_q == GAP_LAST) begin
            gap_q      <= '0;
            fe_start_q <= 1'b1;
            fe_data_q  <= rnw_q ? '0 : wdata_q;
            state_q    <= SM_DATA;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        SM_DATA: begin
          if (fe_done && !fe_start_q) begin
            if (rnw_q) rdata_q <= fe_data_in;
            gap_q   <= '0;
            state_q <= SM_GAP2;
          end
        end
        SM_GAP2: begin
          if (gap_q == GAP_LAST) begin
            gap_q   <= '0;
            state_q <= SM_DONE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        SM_DONE: begin
          ack_q   <= 1'b1;
          gap_q   <= '0;
          state_q <= SM_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          gap_q   <= '0;
          state_q <= SM_IDLE;
        end
      endcase
    end
  end

  assign ready       = ready_q;
  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign fe_start    = fe_start_q;
  assign fe_data_out = fe_data_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_master_protocol.sv
// Bench for spi_master_protocol: front-end/slave loop-back model, transaction-level reference,
// directed scenarios followed by randomized traffic.
module tb_spi_master_protocol;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int GAP    = 4;
  localparam int F      = 8;
  localparam int LAT    = 2 * F + 2 * GAP + 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic              req_rnw = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              ready;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              fe_start;
  logic [DATA_W-1:0] fe_data_out;
  logic [DATA_W-1:0] fe_data_in = '0;
  logic              fe_done = 1'b0;
  logic [2:0]        dbg_state;

  spi_master_protocol #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rnw(req_rnw), .req_addr(req_addr),
    .req_wdata(req_wdata), .ready(ready), .ack(ack), .rdata(rdata), .fe_start(fe_start),
    .fe_data_out(fe_data_out), .fe_data_in(fe_data_in), .fe_done(fe_done),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  typedef struct {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                acc_cyc;
  } txn_t;

  txn_t              pend_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] ref_regs[32];
  logic [DATA_W-1:0] ref_last = '0;
  logic [DATA_W-1:0] slave_regs[32];
  logic [DATA_W-1:0] slave_cfg = '0;
  logic [DATA_W-1:0] cur_word = '0;
  logic [DATA_W-1:0] cfg;
  logic [DATA_W-1:0] exp_rd;
  logic              slave_phase = 1'b0;
  logic              inject_done = 1'b0;
  logic              done_now;
  txn_t              t;
  int fe_cnt = 0;
  int last_done = -100;
  int n_start = 0, n_ack = 0, n_acc = 0;
  int last_acc = 0, last_ack = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // monitors: accept/ack scoreboard plus front-end and slave model, all sampled on negedge
  always @(negedge clk) begin
    done_now = 1'b0;
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      fe_cnt      = 0;
      slave_phase = 1'b0;
      ref_last    = '0;
      last_done   = -100;
    end else begin
      if (req && ready) begin
        t.rnw = req_rnw; t.addr = req_addr; t.wdata = req_wdata; t.acc_cyc = cyc;
        pend_q.push_back(t);
        cfg = '0;
        cfg[ADDR_W-1:0] = req_addr;
        cfg[ADDR_W] = req_rnw;
        exp_q.push_back(cfg);
        exp_q.push_back(req_rnw ? '0 : req_wdata);
        n_acc++;
        last_acc = cyc;
      end
      if (ack) begin
        n_ack++;
        last_ack = cyc;
        if (pend_q.size() == 0) begin
          check("ack_unexpected", 1, 0);
        end else begin
          t = pend_q.pop_front();
          check("ack_latency", cyc - t.acc_cyc, LAT);
          if (t.rnw) begin
            exp_rd   = ref_regs[t.addr];
            ref_last = exp_rd;
          end else begin
            ref_regs[t.addr] = t.wdata;
            exp_rd = ref_last;
          end
          check("rdata_at_ack", rdata, exp_rd);
        end
      end
      if (fe_cnt > 0) begin
        fe_cnt--;
        if (fe_cnt == 0) begin
          done_now  = 1'b1;
          last_done = cyc;
          check("fe_data_stable", fe_data_out, cur_word);
          if (!slave_phase) begin
            slave_cfg   = cur_word;
            slave_phase = 1'b1;
            fe_data_in  = $urandom;
          end else begin
            slave_phase = 1'b0;
            if (slave_cfg[ADDR_W]) begin
              fe_data_in = slave_regs[slave_cfg[ADDR_W-1:0]];
            end else begin
              slave_regs[slave_cfg[ADDR_W-1:0]] = cur_word;
              fe_data_in = $urandom;
            end
          end
        end
      end
      if (inject_done) begin
        done_now   = 1'b1;
        fe_data_in = $urandom;
      end
      if (fe_start) begin
        n_start++;
        check("frame_spacing", (cyc - last_done) > GAP, 1);
        if (exp_q.size() == 0) check("fe_start_unexpected", 1, 0);
        else check("frame_word", fe_data_out, exp_q.pop_front());
        fe_cnt   = F;
        cur_word = fe_data_out;
      end
    end
    fe_done = done_now;
  end

  // driver tasks: all drive at posedge + #1
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 200) begin
      step();
      k++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic rnw, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata, input logic noise);
    step();
    wait_ready();
    req = 1'b1; req_rnw = rnw; req_addr = addr; req_wdata = wdata;
    step();
    req = 1'b0; req_rnw = 1'($urandom); req_addr = ADDR_W'($urandom); req_wdata = $urandom;
    if (noise) begin
      for (int i = 1; i <= 20; i++) begin
        req = 1'($urandom_range(0, 1));
        req_rnw = 1'($urandom); req_addr = ADDR_W'($urandom); req_wdata = $urandom;
        step();
      end
      req = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (pend_q.size() != 0 && k < 300) begin
      step();
      k++;
    end
    if (pend_q.size() != 0) check("idle_timeout", 0, 1);
    step();
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, a0, k;
    logic [DATA_W-1:0] r0, w0;
    for (int i = 0; i < 32; i++) begin
      ref_regs[i]   = '0;
      slave_regs[i] = '0;
    end

    // reset values
    repeat (3) step();
    check("rst_ready", ready, 1);
    check("rst_ack", ack, 0);
    check("rst_fe_start", fe_start, 0);
    check("rst_fe_data_out", fe_data_out, 0);
    check("rst_rdata", rdata, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    step();

    // 1: write
    send(1'b0, 5'h03, 32'hDEADBEEF, 1'b0);
    wait_idle();
    check("t1_rdata_unchanged", rdata, 0);
    check("t1_slave_reg3", slave_regs[3], 32'hDEADBEEF);

    // 2: read back
    send(1'b1, 5'h03, $urandom, 1'b0);
    wait_idle();
    check("t2_rdata", rdata, 32'hDEADBEEF);

    // 3: requests while busy are dropped
    s0 = n_start; a0 = n_ack;
    send(1'b0, 5'h07, $urandom, 1'b1);
    wait_idle();
    check("t3_start_count", n_start - s0, 2);
    check("t3_ack_count", n_ack - a0, 1);

    // 4: back-to-back with req held high
    step();
    wait_ready();
    w0 = $urandom;
    a0 = n_acc;
    req = 1'b1; req_rnw = 1'b0; req_addr = 5'h09; req_wdata = w0;
    k = 0;
    while (n_acc < a0 + 1 && k < 100) begin step(); k++; end
    req_rnw = 1'b1; req_addr = 5'h09; req_wdata = $urandom;
    k = 0;
    while (n_acc < a0 + 2 && k < 100) begin step(); k++; end
    req = 1'b0;
    check("t4_accept_count", n_acc - a0, 2);
    check("t4_accept_after_ack", last_acc - last_ack, 1);
    wait_idle();
    check("t4_rdata", rdata, w0);

    // 5: reset during the data-frame wait
    a0 = n_ack;
    send(1'b1, 5'h03, $urandom, 1'b0);
    repeat (17) step();
    check("t5_in_data_wait", dbg_state, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_ready", ready, 1);
    check("t5_fe_start", fe_start, 0);
    check("t5_ack", ack, 0);
    check("t5_rdata_reset", rdata, 0);
    repeat (40) step();
    check("t5_no_ack", n_ack - a0, 0);
    w0 = $urandom;
    send(1'b0, 5'h0C, w0, 1'b0);
    wait_idle();
    send(1'b1, 5'h0C, $urandom, 1'b0);
    wait_idle();
    check("t5_readback", rdata, w0);

    // 6: spurious fe_done in IDLE and in GAP1
    r0 = rdata; s0 = n_start; a0 = n_ack;
    inject_done = 1'b1;
    step();
    inject_done = 1'b0;
    repeat (3) step();
    check("t6_idle_ready", ready, 1);
    check("t6_idle_state", dbg_state, 0);
    check("t6_idle_rdata", rdata, r0);
    check("t6_idle_no_start", n_start - s0, 0);
    check("t6_idle_no_ack", n_ack - a0, 0);
    w0 = $urandom;
    send(1'b0, 5'h14, w0, 1'b0);
    repeat (10) step();
    check("t6_in_gap1", dbg_state, 2);
    inject_done = 1'b1;
    step();
    inject_done = 1'b0;
    wait_idle();
    check("t6_gap_starts", n_start - s0, 2);
    check("t6_gap_rdata", rdata, r0);
    send(1'b1, 5'h14, $urandom, 1'b0);
    wait_idle();
    check("t6_readback", rdata, w0);

    // randomized traffic on a small address window so reads hit earlier writes
    for (int i = 0; i < 24; i++) begin
      send(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), $urandom, 1'b0);
      repeat ($urandom_range(0, 5)) step();
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
